// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: multicycle controller state encoding, opcode/Funct constants, ALUControl codes.
// Revision 1.0
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SLLV = 3'b110;
  localparam logic [2:0] ALU_SRAV = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: combinational Funct-to-ALUControl map with a valid flag for mapped codes.
// Revision 1.0
`default_nettype none

module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] Funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    case (Funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      FN_SLL:  alu_control = ALU_SLL;
      FN_SLLV: alu_control = ALU_SLLV;
      FN_SRAV: alu_control = ALU_SRAV;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// mc_control: Moore multicycle MIPS-style controller FSM; write enables are gated by reset.
// Revision 1.0
`default_nettype none

module mc_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       ZeroFlag,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       SltOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl
);

  state_t     state;
  state_t     state_next;
  logic [2:0] dec_alu_control;
  logic       dec_funct_valid;
  logic       pc_en_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  alu_decoder u_alu_decoder (
    .Funct       (Funct),
    .alu_control (dec_alu_control),
    .funct_valid (dec_funct_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_en_raw     = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    SltOp         = 1'b0;
    ALUSrcB       = 2'b00;
    PCSrc         = 2'b00;
    ALUControl    = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_en_raw    = 1'b1;
        ALUSrcB      = 2'b01;
        state_next   = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:     state_next = EXECUTE;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR, ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (state == ADDIEXEC)  state_next = ADDIWB;
        else if (Opcode == OP_LW) state_next = MEMREAD;
        else if (Opcode == OP_SW) state_next = MEMWRITE;
        else                      state_next = FETCH;
      end
      MEMREAD: begin
        IorD       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        state_next    = FETCH;
      end
      MEMWRITE: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = FETCH;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = dec_alu_control;
        state_next = ALUWB;
      end
      ALUWB: begin
        // Unmapped Funct still walks the sequence but must not write the register file.
        reg_write_raw = dec_funct_valid;
        RegDst        = 1'b1;
        SltOp         = (Funct == FN_SLT);
        state_next    = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        pc_en_raw  = ZeroFlag;
        state_next = FETCH;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        pc_en_raw  = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset masks every write enable immediately, whatever state the register holds.
  assign PCEn     = pc_en_raw     & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign IRWrite  = ir_write_raw  & ~reset;
  assign RegWrite = reg_write_raw & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// tb_mc_control: directed per-cycle checks of mc_control state and outputs.
// Revision 1.0
`default_nettype none

module tb_mc_control;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       ZeroFlag;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SltOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .ZeroFlag(ZeroFlag),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .SltOp(SltOp),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl)
  );

  // Field order: PCEn IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA SltOp ALUSrcB PCSrc ALUControl
  function automatic logic [15:0] ov(input logic pcen, iord, memw, irw, regdst, m2r, regw,
                                     srca, slt, input logic [1:0] srcb, pcsrc,
                                     input logic [2:0] aluc);
    return {pcen, iord, memw, irw, regdst, m2r, regw, srca, slt, srcb, pcsrc, aluc};
  endfunction

  logic [15:0] obs;
  assign obs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SltOp,
                ALUSrcB, PCSrc, ALUControl};

  localparam logic [15:0] O_FETCH   = 16'b1_0_0_1_0_0_0_0_0_01_00_000;
  localparam logic [15:0] O_FETCHR  = 16'b0_0_0_0_0_0_0_0_0_01_00_000;
  localparam logic [15:0] O_DECODE  = 16'b0_0_0_0_0_0_0_0_0_11_00_000;
  localparam logic [15:0] O_MEMADR  = 16'b0_0_0_0_0_0_0_1_0_10_00_000;
  localparam logic [15:0] O_MEMREAD = 16'b0_1_0_0_0_0_0_0_0_00_00_000;
  localparam logic [15:0] O_MEMWB   = 16'b0_0_0_0_0_1_1_0_0_00_00_000;
  localparam logic [15:0] O_MEMWR   = 16'b0_1_1_0_0_0_0_0_0_00_00_000;
  localparam logic [15:0] O_ADDIWB  = 16'b0_0_0_0_0_0_1_0_0_00_00_000;
  localparam logic [15:0] O_JUMP    = 16'b1_0_0_0_0_0_0_0_0_00_10_000;

  // One cycle: drive inputs after the falling edge, then check the settled state and outputs.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input state_t exp_state, input logic [15:0] exp_out);
    @(negedge clk);
    reset = rst; Opcode = op; Funct = fn; ZeroFlag = z;
    #1;
    checks++;
    assert (dut.state === exp_state) else begin
      errors++;
      $error("FAIL %s state: observed=%0d expected=%0d", tag, dut.state, exp_state);
    end
    checks++;
    assert (obs === exp_out) else begin
      errors++;
      $error("FAIL %s outputs: observed=%b expected=%b", tag, obs, exp_out);
    end
  endtask

  initial begin
    reset = 1'b1; Opcode = 6'd0; Funct = 6'd0; ZeroFlag = 1'b0;
    @(posedge clk);
    cyc("reset_hold", 1'b1, OP_LW, 6'd0, 1'b0, FETCH, O_FETCHR);

    // lw: 5 cycles
    cyc("lw_fetch",   1'b0, OP_LW, 6'd0, 1'b0, FETCH,   O_FETCH);
    cyc("lw_decode",  1'b0, OP_LW, 6'd0, 1'b0, DECODE,  O_DECODE);
    cyc("lw_memadr",  1'b0, OP_LW, 6'd0, 1'b0, MEMADR,  O_MEMADR);
    cyc("lw_memread", 1'b0, OP_LW, 6'd0, 1'b0, MEMREAD, O_MEMREAD);
    cyc("lw_memwb",   1'b0, OP_LW, 6'd0, 1'b0, MEMWB,   O_MEMWB);

    // sw: 4 cycles
    cyc("sw_fetch",   1'b0, OP_SW, 6'd0, 1'b0, FETCH,    O_FETCH);
    cyc("sw_decode",  1'b0, OP_SW, 6'd0, 1'b0, DECODE,   O_DECODE);
    cyc("sw_memadr",  1'b0, OP_SW, 6'd0, 1'b0, MEMADR,   O_MEMADR);
    cyc("sw_memwr",   1'b0, OP_SW, 6'd0, 1'b0, MEMWRITE, O_MEMWR);

    // R-type slt
    cyc("slt_fetch",  1'b0, OP_RTYPE, FN_SLT, 1'b0, FETCH,   O_FETCH);
    cyc("slt_decode", 1'b0, OP_RTYPE, FN_SLT, 1'b0, DECODE,  O_DECODE);
    cyc("slt_exec",   1'b0, OP_RTYPE, FN_SLT, 1'b0, EXECUTE,
        ov(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b100));
    cyc("slt_wb",     1'b0, OP_RTYPE, FN_SLT, 1'b0, ALUWB,
        ov(0,0,0,0,1,0,1,0,1,2'b00,2'b00,3'b000));

    // R-type srav
    cyc("srav_fetch",  1'b0, OP_RTYPE, FN_SRAV, 1'b0, FETCH,   O_FETCH);
    cyc("srav_decode", 1'b0, OP_RTYPE, FN_SRAV, 1'b0, DECODE,  O_DECODE);
    cyc("srav_exec",   1'b0, OP_RTYPE, FN_SRAV, 1'b0, EXECUTE,
        ov(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b111));
    cyc("srav_wb",     1'b0, OP_RTYPE, FN_SRAV, 1'b0, ALUWB,
        ov(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000));

    // R-type sub and or (decoder spot checks)
    cyc("sub_fetch",  1'b0, OP_RTYPE, FN_SUB, 1'b0, FETCH,   O_FETCH);
    cyc("sub_decode", 1'b0, OP_RTYPE, FN_SUB, 1'b0, DECODE,  O_DECODE);
    cyc("sub_exec",   1'b0, OP_RTYPE, FN_SUB, 1'b0, EXECUTE,
        ov(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b001));
    cyc("sub_wb",     1'b0, OP_RTYPE, FN_SUB, 1'b0, ALUWB,
        ov(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000));
    cyc("or_fetch",   1'b0, OP_RTYPE, FN_OR, 1'b0, FETCH,   O_FETCH);
    cyc("or_decode",  1'b0, OP_RTYPE, FN_OR, 1'b0, DECODE,  O_DECODE);
    cyc("or_exec",    1'b0, OP_RTYPE, FN_OR, 1'b0, EXECUTE,
        ov(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b011));
    cyc("or_wb",      1'b0, OP_RTYPE, FN_OR, 1'b0, ALUWB,
        ov(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000));

    // R-type unmapped Funct: ALUControl=000, no RegWrite
    cyc("bad_fn_fetch",  1'b0, OP_RTYPE, 6'b111111, 1'b0, FETCH,   O_FETCH);
    cyc("bad_fn_decode", 1'b0, OP_RTYPE, 6'b111111, 1'b0, DECODE,  O_DECODE);
    cyc("bad_fn_exec",   1'b0, OP_RTYPE, 6'b111111, 1'b0, EXECUTE,
        ov(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000));
    cyc("bad_fn_wb",     1'b0, OP_RTYPE, 6'b111111, 1'b0, ALUWB,
        ov(0,0,0,0,1,0,0,0,0,2'b00,2'b00,3'b000));

    // beq taken, then not taken
    cyc("beq1_fetch",  1'b0, OP_BEQ, 6'd0, 1'b1, FETCH,  O_FETCH);
    cyc("beq1_decode", 1'b0, OP_BEQ, 6'd0, 1'b1, DECODE, O_DECODE);
    cyc("beq1_branch", 1'b0, OP_BEQ, 6'd0, 1'b1, BRANCH,
        ov(1,0,0,0,0,0,0,1,0,2'b00,2'b01,3'b001));
    cyc("beq0_fetch",  1'b0, OP_BEQ, 6'd0, 1'b0, FETCH,  O_FETCH);
    cyc("beq0_decode", 1'b0, OP_BEQ, 6'd0, 1'b0, DECODE, O_DECODE);
    cyc("beq0_branch", 1'b0, OP_BEQ, 6'd0, 1'b0, BRANCH,
        ov(0,0,0,0,0,0,0,1,0,2'b00,2'b01,3'b001));

    // addi
    cyc("addi_fetch",  1'b0, OP_ADDI, 6'd0, 1'b0, FETCH,    O_FETCH);
    cyc("addi_decode", 1'b0, OP_ADDI, 6'd0, 1'b0, DECODE,   O_DECODE);
    cyc("addi_exec",   1'b0, OP_ADDI, 6'd0, 1'b0, ADDIEXEC, O_MEMADR);
    cyc("addi_wb",     1'b0, OP_ADDI, 6'd0, 1'b0, ADDIWB,   O_ADDIWB);

    // j
    cyc("j_fetch",  1'b0, OP_J, 6'd0, 1'b0, FETCH,  O_FETCH);
    cyc("j_decode", 1'b0, OP_J, 6'd0, 1'b0, DECODE, O_DECODE);
    cyc("j_jump",   1'b0, OP_J, 6'd0, 1'b0, JUMP,   O_JUMP);

    // illegal opcode: DECODE straight back to FETCH
    cyc("ill_fetch",  1'b0, 6'b111111, 6'd0, 1'b0, FETCH,  O_FETCH);
    cyc("ill_decode", 1'b0, 6'b111111, 6'd0, 1'b0, DECODE, O_DECODE);
    cyc("ill_after",  1'b0, 6'b111111, 6'd0, 1'b0, FETCH,  O_FETCH);

    // sw aborted by reset in MEMADR
    cyc("swr_decode", 1'b0, OP_SW, 6'd0, 1'b0, DECODE, O_DECODE);
    cyc("swr_memadr", 1'b1, OP_SW, 6'd0, 1'b0, MEMADR, O_MEMADR);
    cyc("swr_hold",   1'b1, OP_SW, 6'd0, 1'b0, FETCH,  O_FETCHR);
    cyc("swr_fetch",  1'b0, OP_SW, 6'd0, 1'b0, FETCH,  O_FETCH);
    cyc("swr_decode2",1'b0, OP_SW, 6'd0, 1'b0, DECODE, O_DECODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high; state returns to FETCH on the next rising edge.
REQ-004 Opcode  in  6  instruction bits [31:26], taken from the instruction register.
REQ-005 Funct  in  6  instruction bits [5:0], taken from the instruction register.
REQ-006 ZeroFlag  in  1  ALU zero flag: 1 when ALUResult==0.
REQ-007 Outputs, all 1 bit: PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SltOp.
REQ-008 ALUSrcB  out  2  SrcB select: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-009 PCSrc  out  2  next-PC select: 00 ALUResult, 01 ALUOut register, 10 jump target.
REQ-010 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll, 110 sllv, 111 srav.

Function
REQ-011 The state machine SHALL be Moore: outputs depend on the current state register only; ALUControl additionally depends on Funct in EXECUTE.
REQ-012 The states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-013 Each state SHALL drive the following outputs (any output not listed is 0):
- FETCH: IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=000, PCSrc=00, IorD=0.
- DECODE: ALUSrcB=11, ALUControl=000.
- MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=000.
- MEMREAD: IorD=1.
- MEMWRITE: IorD=1, MemWrite=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from the decoder.
- ALUWB: RegWrite=1, RegDst=1, SltOp=1 only when Funct=slt.
- ADDIWB: RegWrite=1, RegDst=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=001, PCSrc=01, PCEn=ZeroFlag.
- JUMP: PCSrc=10, PCEn=1.
REQ-014 Opcode decode in DECODE SHALL select the next state as follows:
- 000000 (R-type) -> EXECUTE
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEXEC
- 000010 (j) -> JUMP
- any other opcode -> FETCH, with no register or memory write.
REQ-015 The remaining transitions SHALL be:
- FETCH -> DECODE
- MEMADR -> MEMREAD for lw, MEMWRITE for sw
- MEMREAD -> MEMWB
- EXECUTE -> ALUWB
- ADDIEXEC -> ADDIWB
- MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-016 Cycles per instruction, FETCH inclusive, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-017 The Funct decode SHALL map:
- 100000 -> 000 (add)
- 100010 -> 001 (sub)
- 100100 -> 010 (and)
- 100101 -> 011 (or)
- 101010 -> 100 (slt)
- 000000 -> 101 (sll)
- 000100 -> 110 (sllv)
- 000111 -> 111 (srav).
REQ-018 An unmapped Funct SHALL drive ALUControl=000 in EXECUTE and force RegWrite=0 in ALUWB; the state sequence is unchanged.
REQ-019 SltOp SHALL tell the datapath to write {31'b0, ALUResult[31]} in place of ALUResult.
REQ-020 In BRANCH, PCEn SHALL follow ZeroFlag combinationally within the same cycle.
REQ-021 Opcode and Funct SHALL be sampled only while the instruction register is stable: from DECODE until the return to FETCH.

Reset
REQ-022 While reset is high, PCEn, IRWrite, MemWrite and RegWrite SHALL be 0, regardless of state.
REQ-023 After reset deasserts, the first cycle SHALL be FETCH with the FETCH outputs of REQ-013.
REQ-024 A reset asserted in any state, mid-instruction included, SHALL abort the instruction; no further write enable is asserted for that instruction.

Structure
REQ-025 The package mc_ctrl_pkg SHALL hold the state enum (4-bit encoding), the opcode and Funct constants, and the ALUControl encodings; the ALU and this block share the package.
REQ-026 A combinational sub-module alu_decoder SHALL hold the Funct-to-ALUControl map of REQ-017 and REQ-018; the FSM instantiates it.
REQ-027 The state register SHALL be the only sequential element.

Verification
REQ-028 lw (Opcode=100011): reset, then run -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and MemtoReg=1 only in the 5th cycle; then FETCH.
REQ-029 R-type, Funct=101010 -> EXECUTE with ALUControl=100; ALUWB with SltOp=1 and RegWrite=1. Repeat for Funct=000111 -> ALUControl=111.
REQ-030 beq with ZeroFlag=1 -> PCEn=1 and PCSrc=01 in the 3rd cycle. Repeat with ZeroFlag=0 -> PCEn=0; then FETCH in both runs.
REQ-031 Opcode=111111 -> DECODE goes straight to FETCH; no write enable is asserted.
REQ-032 R-type with Funct=111111 -> ALUWB has RegWrite=0; then FETCH.
REQ-033 sw with reset asserted in MEMADR -> MemWrite is never asserted; FETCH follows in the cycle after reset deasserts.
